// File: rtl/binary_tree_mix_scheduler_if.sv
// Host/actuator bundle for one binary mixing tree scheduler.
// Optional step/hold handshake is present only when BINARY_TREE_MIX_STEP_EN is defined.
interface binary_tree_mix_scheduler_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned NumInlets = 1 << DEPTH;
  localparam int unsigned NumMixers = NumInlets - 1;

  logic                 start;
  logic                 abort;
  logic [CNT_W-1:0]     load_cycles;
  logic [CNT_W-1:0]     mix_cycles;
  logic [CNT_W-1:0]     xfer_cycles;
  logic                 busy;
  logic                 done;
  logic                 aborted;
  logic [NumInlets-1:0] inlet_en;
  logic [NumMixers-1:0] mix_en;
  logic                 xfer_en;
  logic                 outlet_en;
  logic [3:0]           level;
`ifdef BINARY_TREE_MIX_STEP_EN
  logic                 step;
  logic                 hold;
`endif

  // Host / protocol controller side
  modport master (
    output start, abort, load_cycles, mix_cycles, xfer_cycles,
`ifdef BINARY_TREE_MIX_STEP_EN
    output step,
    input  hold,
`endif
    input  busy, done, aborted, inlet_en, mix_en, xfer_en, outlet_en, level
  );

  // Scheduler side
  modport slave (
    input  start, abort, load_cycles, mix_cycles, xfer_cycles,
`ifdef BINARY_TREE_MIX_STEP_EN
    input  step,
    output hold,
`endif
    output busy, done, aborted, inlet_en, mix_en, xfer_en, outlet_en, level
  );
endinterface

// File: rtl/binary_tree_mix_scheduler.sv
// Sequencer for a full binary mixing tree: load inlets, mix level by level from the
// leaves to the root with transfers in between, then drain the root to the outlet.
// Define BINARY_TREE_MIX_STEP_EN to add a HOLD state after every LOAD/MIX/XFER phase
// that waits for a step pulse (adds step input and hold output).
module binary_tree_mix_scheduler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic                        clk,
  input logic                        rst,
  binary_tree_mix_scheduler_if.slave bus
);
  localparam int unsigned      NumInlets = 1 << DEPTH;
  localparam int unsigned      NumMixers = NumInlets - 1;
  localparam logic [3:0]       TopLvl    = 4'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMix,
    StXfer,
    StDrain,
    StDone
`ifdef BINARY_TREE_MIX_STEP_EN
    , StHold
`endif
  } state_e;

  state_e           state_q, state_d;
  state_e           phase_next;
  logic             phase_adv;
  logic [3:0]       lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] mix_q, mix_d;
  logic [CNT_W-1:0] xfer_q, xfer_d;
  logic [CNT_W-1:0] dur;
`ifdef BINARY_TREE_MIX_STEP_EN
  state_e           resume_q, resume_d;
  logic             hold_q, hold_d;
`endif

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;
  logic [NumInlets-1:0] inlet_q, inlet_d;
  logic [NumMixers-1:0] mix_en_q, mix_en_d;
  logic                 xfer_en_q, xfer_en_d;
  logic                 outlet_q, outlet_d;
  logic [3:0]           level_q, level_d;

  // A zero duration would never reach the terminal count; run it as one cycle.
  function automatic logic [CNT_W-1:0] nonzero(input logic [CNT_W-1:0] v);
    return (v == '0) ? CntOne : v;
  endfunction

  // Next-state, duration latching and phase counter
  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    load_d     = load_q;
    mix_d      = mix_q;
    xfer_d     = xfer_q;
    aborted_d  = 1'b0;
    phase_adv  = 1'b0;
    phase_next = StIdle;
    dur        = CntOne;
    cnt_d      = cnt_q;
`ifdef BINARY_TREE_MIX_STEP_EN
    resume_d   = resume_q;
`endif

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLoad;
          lvl_d   = TopLvl;
          load_d  = nonzero(bus.load_cycles);
          mix_d   = nonzero(bus.mix_cycles);
          xfer_d  = nonzero(bus.xfer_cycles);
        end
      end
      StLoad: begin
        if (cnt_q == '0) begin
          phase_adv  = 1'b1;
          phase_next = StMix;
        end
      end
      StMix: begin
        if (cnt_q == '0) begin
          phase_adv  = 1'b1;
          phase_next = (lvl_q != 4'd0) ? StXfer : StDrain;
        end
      end
      StXfer: begin
        if (cnt_q == '0) begin
          phase_adv  = 1'b1;
          phase_next = StMix;
          lvl_d      = lvl_q - 4'd1;
        end
      end
      StDrain: begin
        if (cnt_q == '0) state_d = StDone;
      end
      StDone: state_d = StIdle;
`ifdef BINARY_TREE_MIX_STEP_EN
      StHold: begin
        if (bus.step) state_d = resume_q;
      end
`endif
      default: state_d = StIdle;
    endcase

    if (phase_adv) begin
`ifdef BINARY_TREE_MIX_STEP_EN
      state_d  = StHold;
      resume_d = phase_next;
`else
      state_d  = phase_next;
`endif
    end

    // Abort beats any phase progress; IDLE ignores it so a simultaneous start wins.
    if (state_q != StIdle && bus.abort) begin
      state_d   = StIdle;
      aborted_d = 1'b1;
    end

    case (state_d)
      StLoad:          dur = load_d;
      StMix:           dur = mix_d;
      StXfer, StDrain: dur = xfer_d;
      default:         dur = CntOne;
    endcase

    // Reload on every phase entry, otherwise count down and park at zero.
    if (state_d != state_q) begin
      cnt_d = dur - CntOne;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  // Registered outputs derived from the upcoming state
  always_comb begin
    busy_d    = (state_d != StIdle) && (state_d != StDone);
    done_d    = (state_d == StDone);
    inlet_d   = (state_d == StLoad) ? '1 : '0;
    xfer_en_d = (state_d == StXfer);
    outlet_d  = (state_d == StDrain);
    for (int unsigned i = 0; i < NumMixers; i++) begin
      // Heap node i sits at level floor(log2(i+1)).
      mix_en_d[i] = (state_d == StMix) && ((i + 1) >= (32'd1 << lvl_d)) &&
                    ((i + 1) < (32'd2 << lvl_d));
    end
    case (state_d)
      StMix, StXfer: level_d = lvl_d;
`ifdef BINARY_TREE_MIX_STEP_EN
      StHold:        level_d = level_q;
`endif
      default:       level_d = 4'd0;
    endcase
`ifdef BINARY_TREE_MIX_STEP_EN
    hold_d = (state_d == StHold);
`endif
  end

  // State, counter and latched-duration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      lvl_q    <= '0;
      cnt_q    <= '0;
      load_q   <= '0;
      mix_q    <= '0;
      xfer_q   <= '0;
`ifdef BINARY_TREE_MIX_STEP_EN
      resume_q <= StIdle;
`endif
    end else begin
      state_q  <= state_d;
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      mix_q    <= mix_d;
      xfer_q   <= xfer_d;
`ifdef BINARY_TREE_MIX_STEP_EN
      resume_q <= resume_d;
`endif
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      inlet_q   <= '0;
      mix_en_q  <= '0;
      xfer_en_q <= 1'b0;
      outlet_q  <= 1'b0;
      level_q   <= '0;
`ifdef BINARY_TREE_MIX_STEP_EN
      hold_q    <= 1'b0;
`endif
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      inlet_q   <= inlet_d;
      mix_en_q  <= mix_en_d;
      xfer_en_q <= xfer_en_d;
      outlet_q  <= outlet_d;
      level_q   <= level_d;
`ifdef BINARY_TREE_MIX_STEP_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.inlet_en  = inlet_q;
  assign bus.mix_en    = mix_en_q;
  assign bus.xfer_en   = xfer_en_q;
  assign bus.outlet_en = outlet_q;
  assign bus.level     = level_q;
`ifdef BINARY_TREE_MIX_STEP_EN
  assign bus.hold      = hold_q;
`endif
endmodule
